// File: rtl/aes_decryption.sv
// aes_decryption: iterative AES-128 inverse cipher, one inverse round per clock.
// Optional k10 cache guarded by `AES_DEC_KEY_CACHE_EN (skips KEYEXP on key reuse).
module aes_decryption #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] cipher_in,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] plain_out,
  output logic         out_valid,
  input  logic         out_ready
);

  if (NR != 10) begin : g_nr_check
    $error("aes_decryption: only NR=10 (AES-128) is supported");
  end

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_e;

  state_e       state_q;
  logic [3:0]   rnd_q;
  logic [127:0] key_q;
  logic [127:0] blk_q;
  logic [127:0] plain_q;
  logic         vld_q;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // x^254 is the multiplicative inverse (0 maps to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] x);
    return ginv(rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    unique case (r)
      4'd0:    v = 8'h01;
      4'd1:    v = 8'h02;
      4'd2:    v = 8'h04;
      4'd3:    v = 8'h08;
      4'd4:    v = 8'h10;
      4'd5:    v = 8'h20;
      4'd6:    v = 8'h40;
      4'd7:    v = 8'h80;
      4'd8:    v = 8'h1b;
      4'd9:    v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {
      gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
      gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
      gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
      gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  logic [31:0]  w0, w1, w2, w3, v3, rot, t;
  logic [127:0] key_fwd_d, key_inv_d, isb, ark, imc_d;
  logic         hit;
  logic [127:0] k10c;

  // key step: forward in KEYEXP, inverse in ROUND; one S-box set serves both
  always_comb begin
    {w0, w1, w2, w3} = key_q;
    v3  = w3 ^ w2;
    rot = (state_q == ROUND) ? {v3[23:0], v3[31:24]}
                             : {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]),
           sbox(rot[15:8]),  sbox(rot[7:0])} ^ {rcon(rnd_q), 24'h0};
    key_fwd_d[127:96] = w0 ^ t;
    key_fwd_d[95:64]  = w0 ^ t ^ w1;
    key_fwd_d[63:32]  = w0 ^ t ^ w1 ^ w2;
    key_fwd_d[31:0]   = w0 ^ t ^ w1 ^ w2 ^ w3;
    key_inv_d = {w0 ^ t, w1 ^ w0, w2 ^ w1, v3};
  end

  // inverse round: InvShiftRows+InvSubBytes, AddRoundKey, InvMixColumns
  always_comb begin
    isb   = '0;
    imc_d = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        isb[8*(15-(r+4*c)) +: 8] =
          isbox(blk_q[8*(15-(r+4*((c-r+4)%4))) +: 8]);
    ark = isb ^ key_inv_d;
    for (int c = 0; c < 4; c++)
      imc_d[32*(3-c) +: 32] = inv_mix_col(ark[32*(3-c) +: 32]);
  end

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] ckey_q;
  logic [127:0] ck10_q;
  logic         cvld_q;

  assign hit  = cvld_q && (key_in == ckey_q);
  assign k10c = ck10_q;

  // cache: record the key on a miss, capture k10 as expansion finishes
  always_ff @(posedge clk) begin
    if (rst) begin
      ckey_q <= '0;
      ck10_q <= '0;
      cvld_q <= 1'b0;
    end else if (state_q == IDLE && in_valid && !hit) begin
      ckey_q <= key_in;
      cvld_q <= 1'b0;
    end else if (state_q == KEYEXP && rnd_q == 4'd9) begin
      ck10_q <= key_fwd_d;
      cvld_q <= 1'b1;
    end
  end
`else
  assign hit  = 1'b0;
  assign k10c = '0;
`endif

  // control: accept, expand key, run inverse rounds, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      key_q   <= '0;
      blk_q   <= '0;
      plain_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          if (hit) begin
            key_q   <= k10c;
            blk_q   <= cipher_in ^ k10c;
            rnd_q   <= 4'd9;
            state_q <= ROUND;
          end else begin
            key_q   <= key_in;
            blk_q   <= cipher_in;
            rnd_q   <= 4'd0;
            state_q <= KEYEXP;
          end
        end
        KEYEXP: begin
          key_q <= key_fwd_d;
          if (rnd_q == 4'd9) begin
            blk_q   <= blk_q ^ key_fwd_d;
            state_q <= ROUND;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        ROUND: begin
          key_q <= key_inv_d;
          if (rnd_q == 4'd0) begin
            plain_q <= ark;
            vld_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            blk_q <= imc_d;
            rnd_q <= rnd_q - 4'd1;
          end
        end
        DONE: if (out_ready) begin
          vld_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign plain_out = plain_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_aes_decryption.sv
// tb_aes_decryption: scoreboard bench for aes_decryption.
// Directed FIPS-197 vectors, back-pressure, reset, and model-encrypted loopback.
module tb_aes_decryption;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] cipher_in = '0;
  logic [127:0] key_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] plain_out;
  logic         out_valid;
  logic         out_ready = 1'b1;

  always #5 clk = ~clk;

  aes_decryption dut (
    .clk       (clk),
    .rst       (rst),
    .cipher_in (cipher_in),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plain_out (plain_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    logic [127:0] plain;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [7:0]   sbx[256];
  logic [7:0]   rcs[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                            8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] ckey = '0;
  bit           cvld = 1'b0;
  bit           seen = 1'b0;
  logic [127:0] held = '0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // forward-cipher model used only to build loopback ciphertexts
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] kstep(input logic [127:0] k,
                                         input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {sbx[w3[23:16]] ^ rc, sbx[w3[15:8]], sbx[w3[7:0]], sbx[w3[31:24]]};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = r + 4 * ((c + r) % 4);
        o[127-8*(r+4*c) -: 8] = sbx[s[127-8*src -: 8]];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] key,
                                       input logic [127:0] pt);
    logic [127:0] s, k, t;
    k = key;
    s = pt ^ k;
    for (int r = 1; r <= 10; r++) begin
      k = kstep(k, rcs[r-1]);
      t = sub_shift(s);
      if (r < 10) t = mix(t);
      s = t ^ k;
    end
    return s;
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbx[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbx[0] = 8'h63;
  endtask

  // issue one block; expected result and latency go to the scoreboard
  task automatic send(input logic [127:0] k, input logic [127:0] c,
                      input logic [127:0] p);
    int n;
    bit h;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait: got 0 expected 1 within 200 cycles");
      return;
    end
    h = CACHE && cvld && (k == ckey);
    if (!h) begin
      ckey = k;
      cvld = 1'b1;
    end
    sb.push_back('{p, h ? 10 : 20, cyc + 1});
    key_in    = k;
    cipher_in = c;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    key_in    = {$urandom, $urandom, $urandom, $urandom};
    cipher_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    cvld = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_plain_out", plain_out, 128'(0));
  endtask

  // monitor: pop expectation on each new result, check hold while stalled
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        held = plain_out;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", plain_out);
        end else begin
          e = sb.pop_front();
          chk("plain_out", plain_out, e.plain);
          chk("latency", 128'(cyc - e.acc), 128'(e.lat));
        end
      end else begin
        chk("stall_hold", plain_out, held);
      end
      chk("busy_in_ready", 128'(in_ready), 128'(0));
      if (out_ready) seen = 1'b0;
    end
  end

  initial begin
    int n;
    logic [127:0] k, p;
    build_sbox();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_plain_out", plain_out, 128'(0));

    send(K1, C1, P1);
    drain();
    send(K2, C2, P2);
    drain();

    out_ready = 1'b0;
    send(K1, C1, P1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_seen", 128'(out_valid), 128'(1));
    repeat (7) @(posedge clk);
    #1;
    chk("bp_still_valid", 128'(out_valid), 128'(1));
    chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", 128'(in_ready), 128'(1));
    chk("bp_valid_cleared", 128'(out_valid), 128'(0));

    send(K1, C1, P1);
    send(K1, C1, P1);
    send(K2, C2, P2);
    drain();

    send(K1, C1, P1);
    repeat (13) @(posedge clk);
    #1;
    pulse_reset();
    repeat (30) @(posedge clk);
    #1;
    send(K1, C1, P1);
    drain();
    pulse_reset();
    send(K1, C1, P1);
    drain();

    k = K2;
    for (int i = 0; i < 24; i++) begin
      if (i % 3 != 2) k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      send(k, enc(k, p), p);
    end
    drain();

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
